// File: rtl/uart_ctrl_seq.sv
// uart_ctrl_seq
// Command sequencer between the board buttons/switches and the UART datapath.
// It turns single-cycle button pulses into TX FIFO writes, burst transmits of
// the whole TX FIFO, single-byte reads to the LEDs and flushes of both FIFOs.
// It is the only block that drives the FIFO read/write/clear strobes and the
// transmitter start strobe.
//
// Optional feature macro: UART_CTRL_STATUS_EN
//   When defined, adds err_po[1:0], both bits sticky:
//     bit0 = write attempted while the TX FIFO was full
//     bit1 = read attempted while the selected FIFO was empty
//   Both bits are cleared by btn_clear_pi or by reset.
//
// Ports:
//   clk_pi, rst              UART-domain clock, synchronous active-low reset
//   btn_*_pi                 debounced single-cycle button pulses
//   switch_read_pi           read source: 0 = TX FIFO, 1 = RX FIFO
//   data_in_pi               switch bus; only the low DATA_W bits are used
//   txf_*                    TX FIFO push/pop/flush strobes, data and flags
//   rxf_*                    RX FIFO pop/flush strobes, data and empty flag
//   tx_start_po, tx_data_po  transmitter start pulse and held byte
//   tx_busy_pi               transmitter busy
//   leds_po                  last byte read
//   busy_po                  high whenever the sequencer is not idle
//   err_po                   sticky error flags (UART_CTRL_STATUS_EN only)

module uart_ctrl_seq #(
    parameter int DATA_W    = 8,
    parameter int DATA_IN_W = 32
) (
    input  logic                 clk_pi,
    input  logic                 rst,
    input  logic                 btn_write_pi,
    input  logic                 btn_send_pi,
    input  logic                 btn_read_pi,
    input  logic                 btn_clear_pi,
    input  logic                 switch_read_pi,
    input  logic [DATA_IN_W-1:0] data_in_pi,
    output logic                 txf_wr_en_po,
    output logic [DATA_W-1:0]    txf_wdata_po,
    output logic                 txf_rd_en_po,
    input  logic [DATA_W-1:0]    txf_rdata_pi,
    input  logic                 txf_empty_pi,
    input  logic                 txf_full_pi,
    output logic                 txf_clr_po,
    output logic                 rxf_rd_en_po,
    input  logic [DATA_W-1:0]    rxf_rdata_pi,
    input  logic                 rxf_empty_pi,
    output logic                 rxf_clr_po,
    output logic                 tx_start_po,
    output logic [DATA_W-1:0]    tx_data_po,
    input  logic                 tx_busy_pi,
    output logic [DATA_W-1:0]    leds_po,
`ifdef UART_CTRL_STATUS_EN
    output logic [1:0]           err_po,
`endif
    output logic                 busy_po
);

    // The FIFOs have one cycle of read latency, so every pop is followed by a
    // FETCH state before the popped byte is consumed.
    typedef enum logic [2:0] {
        IDLE,
        SEND_POP,
        SEND_FETCH,
        SEND_LOAD,
        SEND_ACK,
        SEND_WAIT,
        READ_FETCH,
        READ_CAP
    } state_t;

    state_t state;

    // Remembers which FIFO was popped so the capture uses the matching data
    // even if the switch moves while the read is in flight.
    logic read_src;

    logic sel_empty;
    assign sel_empty = switch_read_pi ? rxf_empty_pi : txf_empty_pi;

    logic unused_data_bits;
    assign unused_data_bits = ^data_in_pi[DATA_IN_W-1:DATA_W];

    always_ff @(posedge clk_pi) begin
        if (!rst) begin
            state        <= IDLE;
            read_src     <= 1'b0;
            txf_wr_en_po <= 1'b0;
            txf_wdata_po <= '0;
            txf_rd_en_po <= 1'b0;
            txf_clr_po   <= 1'b0;
            rxf_rd_en_po <= 1'b0;
            rxf_clr_po   <= 1'b0;
            tx_start_po  <= 1'b0;
            tx_data_po   <= '0;
            leds_po      <= '0;
            busy_po      <= 1'b0;
        end else begin
            txf_wr_en_po <= 1'b0;
            txf_rd_en_po <= 1'b0;
            txf_clr_po   <= 1'b0;
            rxf_rd_en_po <= 1'b0;
            rxf_clr_po   <= 1'b0;
            tx_start_po  <= 1'b0;

            // Clear overrides everything, in every state; because it pre-empts
            // SEND_LOAD, a pending transmitter start is never issued.
            if (btn_clear_pi) begin
                state      <= IDLE;
                busy_po    <= 1'b0;
                txf_clr_po <= 1'b1;
                rxf_clr_po <= 1'b1;
                leds_po    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (btn_send_pi) begin
                            state   <= SEND_POP;
                            busy_po <= 1'b1;
                        end else if (btn_write_pi) begin
                            if (!txf_full_pi) begin
                                txf_wr_en_po <= 1'b1;
                                txf_wdata_po <= data_in_pi[DATA_W-1:0];
                            end
                        end else if (btn_read_pi && !sel_empty) begin
                            read_src     <= switch_read_pi;
                            txf_rd_en_po <= ~switch_read_pi;
                            rxf_rd_en_po <= switch_read_pi;
                            state        <= READ_FETCH;
                            busy_po      <= 1'b1;
                        end
                    end
                    SEND_POP: begin
                        if (txf_empty_pi) begin
                            state   <= IDLE;
                            busy_po <= 1'b0;
                        end else begin
                            txf_rd_en_po <= 1'b1;
                            state        <= SEND_FETCH;
                        end
                    end
                    SEND_FETCH: state <= SEND_LOAD;
                    SEND_LOAD: begin
                        tx_data_po  <= txf_rdata_pi;
                        tx_start_po <= 1'b1;
                        state       <= SEND_ACK;
                    end
                    // Wait for the transmitter to acknowledge, then to finish,
                    // before popping the next byte.
                    SEND_ACK: begin
                        if (tx_busy_pi) state <= SEND_WAIT;
                    end
                    SEND_WAIT: begin
                        if (!tx_busy_pi) state <= SEND_POP;
                    end
                    READ_FETCH: state <= READ_CAP;
                    READ_CAP: begin
                        leds_po <= read_src ? rxf_rdata_pi : txf_rdata_pi;
                        state   <= IDLE;
                        busy_po <= 1'b0;
                    end
                    default: begin
                        state   <= IDLE;
                        busy_po <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef UART_CTRL_STATUS_EN
    // Errors are only attempts that actually win arbitration in IDLE; buttons
    // ignored during a sequence or beaten by a higher priority one do not count.
    always_ff @(posedge clk_pi) begin
        if (!rst || btn_clear_pi) begin
            err_po <= 2'b00;
        end else if (state == IDLE && !btn_send_pi) begin
            if (btn_write_pi) begin
                if (txf_full_pi) err_po[0] <= 1'b1;
            end else if (btn_read_pi && sel_empty) begin
                err_po[1] <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_ctrl_seq.sv
// tb_uart_ctrl_seq
// Self-checking bench for uart_ctrl_seq. Surrounds the sequencer with a TX
// FIFO, RX FIFO and transmitter (busy 10 cycles, looped back into the RX
// FIFO), drives a table of single-button vectors, hand-written multi-cycle
// corner cases and a randomized command stream checked against a queue-based
// reference model.

`timescale 1ns/1ps

module tb_uart_ctrl_seq;

    localparam int DATA_W      = 8;
    localparam int DATA_IN_W   = 32;
    localparam int TXD         = 8;
    localparam int RXD         = 16;
    localparam int TX_BUSY_CYC = 10;

    logic                 clk_pi = 1'b0;
    logic                 rst = 1'b0;
    logic                 btn_write_pi = 1'b0;
    logic                 btn_send_pi = 1'b0;
    logic                 btn_read_pi = 1'b0;
    logic                 btn_clear_pi = 1'b0;
    logic                 switch_read_pi = 1'b0;
    logic [DATA_IN_W-1:0] data_in_pi = '0;
    logic                 txf_wr_en_po;
    logic [DATA_W-1:0]    txf_wdata_po;
    logic                 txf_rd_en_po;
    logic [DATA_W-1:0]    txf_rdata_pi = '0;
    logic                 txf_empty_pi = 1'b1;
    logic                 txf_full_pi;
    logic                 txf_full_q = 1'b0;
    logic                 force_full = 1'b0;
    logic                 txf_clr_po;
    logic                 rxf_rd_en_po;
    logic [DATA_W-1:0]    rxf_rdata_pi = '0;
    logic                 rxf_empty_pi = 1'b1;
    logic                 rxf_clr_po;
    logic                 tx_start_po;
    logic [DATA_W-1:0]    tx_data_po;
    logic                 tx_busy_pi = 1'b0;
    logic [DATA_W-1:0]    leds_po;
    logic                 busy_po;
`ifdef UART_CTRL_STATUS_EN
    logic [1:0]           err_po;
`endif

    assign txf_full_pi = txf_full_q | force_full;

    uart_ctrl_seq #(.DATA_W(DATA_W), .DATA_IN_W(DATA_IN_W)) dut (
        .clk_pi         (clk_pi),
        .rst            (rst),
        .btn_write_pi   (btn_write_pi),
        .btn_send_pi    (btn_send_pi),
        .btn_read_pi    (btn_read_pi),
        .btn_clear_pi   (btn_clear_pi),
        .switch_read_pi (switch_read_pi),
        .data_in_pi     (data_in_pi),
        .txf_wr_en_po   (txf_wr_en_po),
        .txf_wdata_po   (txf_wdata_po),
        .txf_rd_en_po   (txf_rd_en_po),
        .txf_rdata_pi   (txf_rdata_pi),
        .txf_empty_pi   (txf_empty_pi),
        .txf_full_pi    (txf_full_pi),
        .txf_clr_po     (txf_clr_po),
        .rxf_rd_en_po   (rxf_rd_en_po),
        .rxf_rdata_pi   (rxf_rdata_pi),
        .rxf_empty_pi   (rxf_empty_pi),
        .rxf_clr_po     (rxf_clr_po),
        .tx_start_po    (tx_start_po),
        .tx_data_po     (tx_data_po),
        .tx_busy_pi     (tx_busy_pi),
        .leds_po        (leds_po),
`ifdef UART_CTRL_STATUS_EN
        .err_po         (err_po),
`endif
        .busy_po        (busy_po)
    );

    always #5 clk_pi = ~clk_pi;

    // Environment: FIFOs with one cycle of read latency, transmitter that stays
    // busy for TX_BUSY_CYC cycles and loops each finished byte into the RX FIFO.
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic [7:0] tx_cur = '0;
    int         tx_cnt = 0;

    always @(posedge clk_pi) begin
        if (txf_clr_po) txq.delete();
        else if (txf_wr_en_po && txq.size() < TXD) txq.push_back(txf_wdata_po);
        else if (txf_rd_en_po && txq.size() > 0) txf_rdata_pi <= txq.pop_front();
        if (rxf_clr_po) rxq.delete();
        else if (rxf_rd_en_po && rxq.size() > 0) rxf_rdata_pi <= rxq.pop_front();
        if (tx_start_po) begin
            tx_busy_pi <= 1'b1;
            tx_cnt     <= TX_BUSY_CYC;
            tx_cur     <= tx_data_po;
        end else if (tx_cnt > 0) begin
            tx_cnt <= tx_cnt - 1;
            if (tx_cnt == 1) begin
                tx_busy_pi <= 1'b0;
                if (rxq.size() < RXD) rxq.push_back(tx_cur);
            end
        end
        txf_empty_pi <= (txq.size() == 0);
        txf_full_q   <= (txq.size() >= TXD);
        rxf_empty_pi <= (rxq.size() == 0);
    end

    // Monitor: event counters and protocol violation counters.
    int         wr_cnt = 0, txrd_cnt = 0, start_cnt = 0;
    int         start_busy_viol = 0, hold_viol = 0, width_viol = 0, clr_pair_viol = 0;
    logic [7:0] start_log[$];
    logic [7:0] last_start = '0;
    logic [5:0] prev_strobes = '0;

    always @(negedge clk_pi) begin : monitor
        logic [5:0] s;
        s = {txf_wr_en_po, txf_rd_en_po, rxf_rd_en_po, txf_clr_po, rxf_clr_po, tx_start_po};
        if ((s & prev_strobes) != 6'd0) width_viol++;
        prev_strobes = s;
        if (txf_wr_en_po) wr_cnt++;
        if (txf_rd_en_po) txrd_cnt++;
        if (tx_start_po) begin
            start_cnt++;
            start_log.push_back(tx_data_po);
            last_start = tx_data_po;
            if (tx_busy_pi) start_busy_viol++;
        end else if (tx_busy_pi && tx_data_po != last_start) begin
            hold_viol++;
        end
        if (txf_clr_po != rxf_clr_po) clr_pair_viol++;
    end

    int total = 0;
    int bad = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one cycle of buttons; returns at the negedge after the sampling
    // edge, where the registered response is visible.
    task automatic applyStimulus(input logic w, input logic s, input logic r, input logic c,
                                 input logic sw, input logic [31:0] d);
        @(negedge clk_pi);
        btn_write_pi   = w;
        btn_send_pi    = s;
        btn_read_pi    = r;
        btn_clear_pi   = c;
        switch_read_pi = sw;
        data_in_pi     = d;
        @(negedge clk_pi);
        btn_write_pi = 1'b0;
        btn_send_pi  = 1'b0;
        btn_read_pi  = 1'b0;
        btn_clear_pi = 1'b0;
    endtask

    task automatic waitIdle(input string name, input int budget);
        int n = 0;
        while (busy_po && n < budget) begin
            @(negedge clk_pi);
            n++;
        end
        checkOutput({name, " idle"}, busy_po, 1'b0);
    endtask

    task automatic waitTxIdle(input string name, input int budget);
        int n = 0;
        while (tx_busy_pi && n < budget) begin
            @(negedge clk_pi);
            n++;
        end
        checkOutput({name, " tx idle"}, tx_busy_pi, 1'b0);
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_pi);
    endtask

    typedef struct {
        logic        w, s, r, c, sw;
        logic [31:0] d;
        logic        exp_wr;
        logic [7:0]  exp_wdata;
        logic        exp_txrd, exp_rxrd, exp_clr, exp_busy;
        logic [7:0]  exp_leds;
        logic [1:0]  exp_err;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int         s0, rd0, n, mism;
        logic [7:0] mtx[$];
        logic [7:0] mrx[$];
        logic [7:0] exp_log[$];
        logic [7:0] mleds, b;
        int         base;

        //            w  s  r  c  sw data           wr wdata  txrd rxrd clr busy leds   err
        vecs[0]  = '{1, 0, 0, 0, 0, 32'h000000A5, 1, 8'hA5, 0, 0, 0, 0, 8'h00, 2'b00};
        vecs[1]  = '{1, 0, 0, 0, 0, 32'h1234563C, 1, 8'h3C, 0, 0, 0, 0, 8'h00, 2'b00};
        vecs[2]  = '{1, 0, 0, 1, 0, 32'h000000FF, 0, 8'h00, 0, 0, 1, 0, 8'h00, 2'b00};
        vecs[3]  = '{1, 0, 0, 0, 0, 32'hABCDEF77, 1, 8'h77, 0, 0, 0, 0, 8'h00, 2'b00};
        vecs[4]  = '{1, 0, 1, 0, 0, 32'h0000005A, 1, 8'h5A, 0, 0, 0, 0, 8'h00, 2'b00};
        vecs[5]  = '{0, 0, 1, 0, 0, 32'h00000000, 0, 8'h00, 1, 0, 0, 1, 8'h77, 2'b00};
        vecs[6]  = '{0, 0, 1, 0, 1, 32'h00000000, 0, 8'h00, 0, 0, 0, 0, 8'h77, 2'b10};
        vecs[7]  = '{1, 1, 0, 0, 0, 32'h00000099, 0, 8'h00, 0, 0, 0, 1, 8'h77, 2'b10};
        vecs[8]  = '{0, 0, 1, 0, 1, 32'h00000000, 0, 8'h00, 0, 1, 0, 1, 8'h5A, 2'b10};
        vecs[9]  = '{0, 0, 0, 1, 0, 32'h00000000, 0, 8'h00, 0, 0, 1, 0, 8'h00, 2'b00};
        vecs[10] = '{0, 1, 1, 0, 1, 32'h00000000, 0, 8'h00, 0, 0, 0, 1, 8'h00, 2'b00};

        $display("[TB] reset");
        rst = 1'b0;
        waitCycles(3);
        checkOutput("reset busy", busy_po, 1'b0);
        checkOutput("reset leds", leds_po, 8'h00);
        checkOutput("reset tx_data", tx_data_po, 8'h00);
        checkOutput("reset strobes",
                    {txf_wr_en_po, txf_rd_en_po, rxf_rd_en_po, txf_clr_po, rxf_clr_po, tx_start_po}, 6'd0);
`ifdef UART_CTRL_STATUS_EN
        checkOutput("reset err", err_po, 2'b00);
`endif
        rst = 1'b1;

        $display("[TB] vector table");
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].w, vecs[i].s, vecs[i].r, vecs[i].c, vecs[i].sw, vecs[i].d);
            checkOutput($sformatf("vec%0d wr_en", i), txf_wr_en_po, vecs[i].exp_wr);
            if (vecs[i].exp_wr) checkOutput($sformatf("vec%0d wdata", i), txf_wdata_po, vecs[i].exp_wdata);
            checkOutput($sformatf("vec%0d txf_rd_en", i), txf_rd_en_po, vecs[i].exp_txrd);
            checkOutput($sformatf("vec%0d rxf_rd_en", i), rxf_rd_en_po, vecs[i].exp_rxrd);
            checkOutput($sformatf("vec%0d clr", i), {txf_clr_po, rxf_clr_po}, {2{vecs[i].exp_clr}});
            checkOutput($sformatf("vec%0d busy", i), busy_po, vecs[i].exp_busy);
            waitIdle($sformatf("vec%0d", i), 200);
            checkOutput($sformatf("vec%0d leds", i), leds_po, vecs[i].exp_leds);
`ifdef UART_CTRL_STATUS_EN
            checkOutput($sformatf("vec%0d err", i), err_po, vecs[i].exp_err);
`endif
        end

        $display("[TB] burst send of two bytes");
        applyStimulus(1, 0, 0, 0, 0, 32'h000000A5);
        applyStimulus(1, 0, 0, 0, 0, 32'h0000003C);
        s0 = start_cnt;
        base = start_log.size();
        applyStimulus(0, 1, 0, 0, 0, 32'h0);
        waitIdle("burst", 300);
        checkOutput("burst start count", start_cnt - s0, 2);
        if (start_log.size() >= base + 2) begin
            checkOutput("burst byte0", start_log[base], 8'hA5);
            checkOutput("burst byte1", start_log[base + 1], 8'h3C);
        end
        checkOutput("start while busy", start_busy_viol, 0);

        $display("[TB] loopback read");
        applyStimulus(0, 0, 1, 0, 1, 32'h0);
        checkOutput("loop rxf_rd_en", rxf_rd_en_po, 1'b1);
        checkOutput("loop leds cyc1", leds_po, 8'h00);
        @(negedge clk_pi);
        checkOutput("loop leds cyc2", leds_po, 8'h00);
        @(negedge clk_pi);
        checkOutput("loop leds cyc3", leds_po, 8'hA5);
        waitIdle("loop", 20);

        $display("[TB] clear during transmit wait");
        applyStimulus(1, 0, 0, 0, 0, 32'h00000011);
        applyStimulus(1, 0, 0, 0, 0, 32'h00000022);
        applyStimulus(1, 0, 0, 0, 0, 32'h00000033);
        s0 = start_cnt;
        applyStimulus(0, 1, 0, 0, 0, 32'h0);
        n = 0;
        while (!tx_busy_pi && n < 20) begin
            @(negedge clk_pi);
            n++;
        end
        checkOutput("midclr tx busy seen", tx_busy_pi, 1'b1);
        waitCycles(3);
        applyStimulus(0, 0, 0, 1, 0, 32'h0);
        checkOutput("midclr clr pair", {txf_clr_po, rxf_clr_po}, 2'b11);
        checkOutput("midclr leds", leds_po, 8'h00);
        checkOutput("midclr busy", busy_po, 1'b0);
        waitCycles(60);
        checkOutput("midclr start count", start_cnt - s0, 1);
        waitTxIdle("midclr", 30);

        $display("[TB] clear right after pop");
        applyStimulus(1, 0, 0, 0, 0, 32'h00000044);
        s0 = start_cnt;
        applyStimulus(0, 1, 0, 0, 0, 32'h0);
        n = 0;
        while (!txf_rd_en_po && n < 10) begin
            @(negedge clk_pi);
            n++;
        end
        checkOutput("loadclr pop seen", txf_rd_en_po, 1'b1);
        btn_clear_pi = 1'b1;
        @(negedge clk_pi);
        btn_clear_pi = 1'b0;
        checkOutput("loadclr clr", txf_clr_po, 1'b1);
        waitCycles(30);
        checkOutput("loadclr no start", start_cnt - s0, 0);

        $display("[TB] write when full and clear+write");
        force_full = 1'b1;
        s0 = wr_cnt;
        applyStimulus(1, 0, 0, 0, 0, 32'h000000EE);
        checkOutput("full wr_en", txf_wr_en_po, 1'b0);
`ifdef UART_CTRL_STATUS_EN
        checkOutput("full err0", err_po[0], 1'b1);
`endif
        force_full = 1'b0;
        applyStimulus(1, 0, 0, 1, 0, 32'h000000EF);
        checkOutput("clrwr clr", txf_clr_po, 1'b1);
        waitCycles(2);
        checkOutput("full/clrwr no push", wr_cnt - s0, 0);
`ifdef UART_CTRL_STATUS_EN
        checkOutput("clrwr err", err_po, 2'b00);
`endif

        $display("[TB] reset mid-sequence");
        applyStimulus(1, 0, 0, 0, 0, 32'h00000055);
        s0 = start_cnt;
        rd0 = txrd_cnt;
        applyStimulus(0, 1, 0, 0, 0, 32'h0);
        rst = 1'b0;
        @(negedge clk_pi);
        rst = 1'b1;
        checkOutput("midrst busy", busy_po, 1'b0);
        checkOutput("midrst tx_data", tx_data_po, 8'h00);
        checkOutput("midrst strobes",
                    {txf_wr_en_po, txf_rd_en_po, rxf_rd_en_po, txf_clr_po, rxf_clr_po, tx_start_po}, 6'd0);
        waitCycles(30);
        checkOutput("midrst no start", start_cnt - s0, 0);
        checkOutput("midrst no pop", txrd_cnt - rd0, 0);

        $display("[TB] randomized commands");
        waitTxIdle("rand pre", 30);
        applyStimulus(0, 0, 0, 1, 0, 32'h0);
        mleds = 8'h00;
        base = start_log.size();
        for (int k = 0; k < 60; k++) begin
            int op;
            logic sw;
            logic [31:0] d;
            op = $urandom_range(0, 9);
            sw = 1'($urandom_range(0, 1));
            d  = $urandom;
            if (op <= 3 || op >= 8) begin
                applyStimulus(1, 0, 0, 0, 0, d);
                if (mtx.size() < TXD) mtx.push_back(d[7:0]);
            end else if (op <= 5) begin
                applyStimulus(0, 0, 1, 0, sw, d);
                if (sw && mrx.size() > 0) mleds = mrx.pop_front();
                else if (!sw && mtx.size() > 0) mleds = mtx.pop_front();
            end else if (op == 6) begin
                applyStimulus(0, 1, 0, 0, sw, d);
                while (mtx.size() > 0) begin
                    b = mtx.pop_front();
                    exp_log.push_back(b);
                    if (mrx.size() < RXD) mrx.push_back(b);
                end
            end else begin
                applyStimulus(0, 0, 0, 1, sw, d);
                mtx.delete();
                mrx.delete();
                mleds = 8'h00;
            end
            waitIdle($sformatf("rand%0d", k), 400);
            checkOutput($sformatf("rand%0d leds", k), leds_po, mleds);
            checkOutput($sformatf("rand%0d starts", k), start_log.size() - base, exp_log.size());
        end
        mism = 0;
        for (int i = 0; i < exp_log.size(); i++) begin
            if (base + i >= start_log.size() || start_log[base + i] != exp_log[i]) mism++;
        end
        checkOutput("rand start bytes", mism, 0);

        checkOutput("strobe width", width_viol, 0);
        checkOutput("clr pairing", clr_pair_viol, 0);
        checkOutput("tx_data hold", hold_viol, 0);
        checkOutput("start while busy final", start_busy_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
